// File: rtl/sar_scan_sequencer.sv
// Multi-channel scan sequencer in front of a SAR ADC. It steps an analog mux through the enabled
// channels and lets the mux settle once per channel. It then runs 2**AVG_LOG2 conversions and
// emits one averaged result per channel on a valid/ready port. A per-conversion watchdog aborts
// conversions that never complete.
`timescale 1ns/1ps
module sar_scan_sequencer #(
    parameter int ADC_WIDTH  = 8,
    parameter int NCH        = 4,
    parameter int CH_W       = $clog2(NCH),
    parameter int AVG_LOG2   = 2,
    parameter int SETTLE_CYC = 3,
    parameter int TIMEOUT    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       en_mask,
    input  logic                 scan_go,
    input  logic                 cont,
    output logic [CH_W-1:0]      mux_sel,
    output logic                 adc_start,
    input  logic                 adc_den,
    input  logic [ADC_WIDTH-1:0] adc_dout,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [CH_W-1:0]      res_ch,
    output logic [ADC_WIDTH-1:0] res_data,
    output logic                 res_err,
    output logic                 busy,
    output logic                 scan_done
);

    localparam int ACC_W = ADC_WIDTH + AVG_LOG2;
    localparam int SC_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int ST_W  = $clog2(SETTLE_CYC + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [SC_W-1:0] LastSample = SC_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        StIdle, StSelect, StSettle, StStart, StWait, StOutput, StNext
    } state_t;

    state_t               state_q, state_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic [NCH-1:0]       scan_mask_q, scan_mask_d;
    logic                 busy_q, busy_d;
    logic [ST_W-1:0]      settle_cnt_q, settle_cnt_d;
    logic [WD_W-1:0]      wd_cnt_q, wd_cnt_d;
    logic [SC_W-1:0]      sample_cnt_q, sample_cnt_d;
    logic [ACC_W-1:0]     acc_q, acc_d, acc_sum;
    logic [ADC_WIDTH-1:0] res_data_q, res_data_d;
    logic                 res_err_q, res_err_d;
    logic [CH_W:0]        pick;

    // Returns {found, index} of the lowest set bit of mask at or above position lo.
    function automatic logic [CH_W:0] lowest_from(input logic [NCH-1:0] mask, input int lo);
        logic [CH_W:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i] && i >= lo) r = {1'b1, CH_W'(i)};
        end
        return r;
    endfunction

    // State and datapath registers; reset aborts any conversion at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            ch_q         <= '0;
            scan_mask_q  <= '0;
            busy_q       <= 1'b0;
            settle_cnt_q <= '0;
            wd_cnt_q     <= '0;
            sample_cnt_q <= '0;
            acc_q        <= '0;
            res_data_q   <= '0;
            res_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            scan_mask_q  <= scan_mask_d;
            busy_q       <= busy_d;
            settle_cnt_q <= settle_cnt_d;
            wd_cnt_q     <= wd_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            acc_q        <= acc_d;
            res_data_q   <= res_data_d;
            res_err_q    <= res_err_d;
        end
    end

    // Next-state logic and Moore-style strobes.
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        scan_mask_d  = scan_mask_q;
        busy_d       = busy_q;
        settle_cnt_d = settle_cnt_q;
        wd_cnt_d     = wd_cnt_q;
        sample_cnt_d = sample_cnt_q;
        acc_d        = acc_q;
        res_data_d   = res_data_q;
        res_err_d    = res_err_q;
        acc_sum      = acc_q + ACC_W'(adc_dout);
        pick         = '0;
        adc_start    = 1'b0;
        scan_done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (scan_go) begin
                    scan_mask_d = en_mask;
                    busy_d      = 1'b1;
                    pick        = lowest_from(en_mask, 0);
                    if (pick[CH_W]) begin
                        ch_d    = pick[CH_W-1:0];
                        state_d = StSelect;
                    end else begin
                        // Empty mask: go straight to the end-of-scan step.
                        state_d = StNext;
                    end
                end
            end
            StSelect: begin
                settle_cnt_d = ST_W'(SETTLE_CYC);
                acc_d        = '0;
                sample_cnt_d = '0;
                state_d      = StSettle;
            end
            StSettle: begin
                if (settle_cnt_q == '0) state_d = StStart;
                else                    settle_cnt_d = settle_cnt_q - 1'b1;
            end
            StStart: begin
                adc_start = 1'b1;
                wd_cnt_d  = WD_W'(TIMEOUT);
                state_d   = StWait;
            end
            StWait: begin
                if (adc_den) begin
                    acc_d = acc_sum;
                    if (sample_cnt_q == LastSample) begin
                        res_data_d = ADC_WIDTH'(acc_sum >> AVG_LOG2);
                        res_err_d  = 1'b0;
                        state_d    = StOutput;
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                        state_d      = StStart;
                    end
                end else if (wd_cnt_q == '0) begin
                    res_err_d  = 1'b1;
                    res_data_d = '0;
                    state_d    = StOutput;
                end else begin
                    wd_cnt_d = wd_cnt_q - 1'b1;
                end
            end
            StOutput: begin
                if (res_ready) begin
                    res_err_d = 1'b0;
                    state_d   = StNext;
                end
            end
            StNext: begin
                pick = lowest_from(scan_mask_q, int'(ch_q) + 1);
                if (pick[CH_W]) begin
                    ch_d    = pick[CH_W-1:0];
                    state_d = StSelect;
                end else begin
                    scan_done = 1'b1;
                    if (cont) begin
                        scan_mask_d = en_mask;
                        pick        = lowest_from(en_mask, 0);
                        if (pick[CH_W]) begin
                            ch_d    = pick[CH_W-1:0];
                            state_d = StSelect;
                        end
                    end else begin
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign mux_sel   = ch_q;
    assign res_ch    = ch_q;
    assign res_valid = (state_q == StOutput);
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sar_scan_sequencer.sv
// Scoreboard bench for sar_scan_sequencer with a behavioural SAR ADC (den 9 cycles after start).
`timescale 1ns/1ps
module tb_sar_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] en_mask = '0;
    logic       scan_go = 1'b0;
    logic       cont = 1'b0;
    logic [1:0] mux_sel;
    logic       adc_start;
    logic       adc_den = 1'b0;
    logic [7:0] adc_dout = '0;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic [1:0] res_ch;
    logic [7:0] res_data;
    logic       res_err;
    logic       busy;
    logic       scan_done;

    sar_scan_sequencer #(
        .ADC_WIDTH(8), .NCH(4), .AVG_LOG2(2), .SETTLE_CYC(3), .TIMEOUT(32)
    ) dut (
        .clk(clk), .rst(rst), .en_mask(en_mask), .scan_go(scan_go), .cont(cont),
        .mux_sel(mux_sel), .adc_start(adc_start), .adc_den(adc_den), .adc_dout(adc_dout),
        .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch), .res_data(res_data),
        .res_err(res_err), .busy(busy), .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    exp_t e_out;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] vals [0:15];
    int   adc_cnt = 0;
    int   k_idx = 0;
    logic [7:0] adc_pend = '0;
    int   sup_ch = -1;

    int   start_cnt = 0;
    int   done_cnt = 0;
    int   width_err = 0;
    int   saw_ch2 = 0;
    logic prev_start = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected average for one channel from the ADC sample table.
    function automatic exp_t exp_for(input int ch);
        int s;
        exp_t e;
        s = 0;
        for (int k = 0; k < 4; k++) s += int'(vals[ch*4+k]);
        e.ch   = 2'(ch);
        e.data = 8'(s / 4);
        e.err  = 1'b0;
        return e;
    endfunction

    task automatic push_mask(input logic [3:0] m);
        for (int c = 0; c < 4; c++) if (m[c]) sb_q.push_back(exp_for(c));
    endtask

    task automatic go(input logic [3:0] m);
        @(negedge clk);
        en_mask = m;
        scan_go = 1'b1;
        @(negedge clk);
        scan_go = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(busy), 0);
    endtask

    // ADC model: captures channel/sample at start, answers 9 cycles later unless suppressed.
    always @(negedge clk) begin
        adc_den = 1'b0;
        if (rst) begin
            adc_cnt = 0;
            k_idx   = 0;
        end else begin
            if (res_valid && res_ready) k_idx = 0;
            if (adc_cnt > 0) begin
                adc_cnt--;
                if (adc_cnt == 0) begin
                    adc_den  = 1'b1;
                    adc_dout = adc_pend;
                end
            end
            if (adc_start) begin
                adc_pend = vals[int'(mux_sel)*4 + (k_idx % 4)];
                k_idx++;
                if (int'(mux_sel) != sup_ch) adc_cnt = 9;
            end
        end
    end

    // Strobe monitor: start count, start width, channel-2 selection, scan_done count.
    always @(negedge clk) begin
        if (!rst) begin
            if (adc_start) start_cnt++;
            if (adc_start && prev_start) width_err++;
            if (adc_start && mux_sel == 2'd2) saw_ch2++;
            if (scan_done) done_cnt++;
            prev_start = adc_start;
        end else begin
            prev_start = 1'b0;
        end
    end

    // Scoreboard: compare every accepted result with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected", 32'(res_valid), 0);
            end else begin
                e_out = sb_q.pop_front();
                check("res_ch", 32'(res_ch), 32'(e_out.ch));
                check("res_data", 32'(res_data), 32'(e_out.data));
                check("res_err", 32'(res_err), 32'(e_out.err));
            end
        end
    end

    initial begin : main
        int n;
        logic [1:0] hold_ch;
        logic [7:0] hold_data;
        int viol;
        int busy_drop;

        vals[0]  = 8'd10;  vals[1]  = 8'd12;  vals[2]  = 8'd14;  vals[3]  = 8'd16;
        vals[4]  = 8'd255; vals[5]  = 8'd255; vals[6]  = 8'd255; vals[7]  = 8'd255;
        vals[8]  = 8'd100; vals[9]  = 8'd101; vals[10] = 8'd102; vals[11] = 8'd103;
        vals[12] = 8'd0;   vals[13] = 8'd1;   vals[14] = 8'd2;   vals[15] = 8'd3;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_outputs", {24'd0, adc_start, busy, res_valid, res_err, scan_done, mux_sel, 1'b0}, 0);
        check("rst_res", {22'd0, res_ch, res_data}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single scan with latency check.
        start_cnt = 0; done_cnt = 0;
        push_mask(4'b1011);
        en_mask = 4'b1011;
        scan_go = 1'b1;
        @(posedge clk);                      // edge T
        @(negedge clk);
        scan_go = 1'b0;
        check("lat_start_t0", 32'(adc_start), 0);
        check("busy_set", 32'(busy), 1);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            check("lat_start_early", 32'(adc_start), 0);
            if (i == 1) check("lat_mux_sel", 32'(mux_sel), 0);
        end
        @(negedge clk);
        check("lat_start_t5", 32'(adc_start), 1);
        wait_idle(1000);
        check("single_starts", start_cnt, 12);
        check("single_done", done_cnt, 1);
        check("single_ch2", saw_ch2, 0);
        check("single_sb_empty", sb_q.size(), 0);

        // Backpressure on the first result.
        start_cnt = 0;
        res_ready = 1'b0;
        push_mask(4'b1011);
        go(4'b1011);
        n = 0;
        while (!res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid", 32'(res_valid), 1);
        hold_ch = res_ch;
        hold_data = res_data;
        n = start_cnt;
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (!res_valid || res_ch !== hold_ch || res_data !== hold_data) viol++;
        end
        check("bp_stable", viol, 0);
        check("bp_no_start", start_cnt - n, 0);
        res_ready = 1'b1;
        wait_idle(1000);
        check("bp_starts", start_cnt, 12);
        check("bp_sb_empty", sb_q.size(), 0);

        // Watchdog on channel 1.
        start_cnt = 0;
        sup_ch = 1;
        sb_q.push_back(exp_for(0));
        sb_q.push_back('{ch: 2'd1, data: 8'd0, err: 1'b1});
        sb_q.push_back(exp_for(3));
        go(4'b1011);
        wait_idle(1000);
        sup_ch = -1;
        check("wd_starts", start_cnt, 9);
        check("wd_sb_empty", sb_q.size(), 0);

        // Continuous mode on channel 0, then drop cont mid-scan.
        done_cnt = 0;
        busy_drop = 0;
        cont = 1'b1;
        sb_q.push_back(exp_for(0));
        go(4'b0001);
        n = 0;
        while (done_cnt < 3 && n < 1000) begin
            if (scan_done && cont) sb_q.push_back(exp_for(0));
            if (!busy) busy_drop++;
            @(negedge clk);
            n++;
        end
        if (scan_done && cont) sb_q.push_back(exp_for(0));
        repeat (5) @(negedge clk);
        cont = 1'b0;
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("cont_idle", 32'(busy), 0);
        check("cont_busy_held", busy_drop, 0);
        check("cont_done", done_cnt, 4);
        check("cont_sb_empty", sb_q.size(), 0);

        // Empty mask.
        start_cnt = 0;
        en_mask = 4'b0000;
        scan_go = 1'b1;
        @(posedge clk);
        @(negedge clk);
        scan_go = 1'b0;
        check("empty_done", 32'(scan_done), 1);
        check("empty_busy", 32'(busy), 1);
        @(negedge clk);
        check("empty_done_off", 32'(scan_done), 0);
        check("empty_busy_off", 32'(busy), 0);
        check("empty_starts", start_cnt, 0);

        // Asynchronous reset while channel 1 is converting.
        sb_q.push_back(exp_for(0));
        go(4'b1011);
        n = 0;
        while (!(adc_start && mux_sel == 2'd1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach_ch1", 32'(mux_sel), 1);
        #1 rst = 1'b1;
        #1;
        check("arst_start", 32'(adc_start), 0);
        check("arst_outputs", {25'd0, busy, res_valid, res_err, scan_done, mux_sel, 1'b0}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("arst_sb_empty", sb_q.size(), 0);
        start_cnt = 0;
        push_mask(4'b1011);
        go(4'b1011);
        check("restart_mux", 32'(mux_sel), 0);
        wait_idle(1000);
        check("restart_starts", start_cnt, 12);
        check("restart_sb_empty", sb_q.size(), 0);
        check("start_width", width_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
